// File: rtl/mul_share_arbiter_pkg.sv
// Shared state encoding and width helper for the shared-multiplier arbiter.
// Imported by the interface, the round-robin picker and the top.
package mul_share_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mul_share_arbiter_if.sv
// Requester, response and multiplier-side signals of the shared multiplier.
// slave is the arbiter side, master is the environment side.
interface mul_share_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int W     = 5,
    parameter int RW    = 8,
    parameter int IDW   = mul_share_arbiter_pkg::clog2(N_REQ)
);
    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] req_m;
    logic [N_REQ*W-1:0] req_q;
    logic [N_REQ-1:0]   gnt;
    logic               rsp_valid;
    logic [IDW-1:0]     rsp_id;
    logic [RW-1:0]      rsp_result;
    logic               rsp_ready;
    logic               mul_start;
    logic [W-1:0]       mul_m;
    logic [W-1:0]       mul_q;
    logic [RW-1:0]      mul_result;

    modport slave (
        input  req, req_m, req_q, rsp_ready, mul_result,
        output gnt, rsp_valid, rsp_id, rsp_result,
        output mul_start, mul_m, mul_q
    );

    modport master (
        output req, req_m, req_q, rsp_ready, mul_result,
        input  gnt, rsp_valid, rsp_id, rsp_result,
        input  mul_start, mul_m, mul_q
    );
endinterface

// File: rtl/mul_share_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after ptr wins.
// The pointer register itself lives in the parent.
module rr_arbiter
    import mul_share_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic             any,
    output logic [IDW-1:0]   win_id,
    output logic [N_REQ-1:0] win_onehot
);
    int idx;

    assign any = |req;

    // Walk from farthest to nearest so the nearest set request overwrites.
    always_comb begin
        idx        = 0;
        win_id     = '0;
        win_onehot = '0;
        for (int o = N_REQ - 1; o >= 0; o--) begin
            idx = (int'(ptr) + o) % N_REQ;
            if (req[idx]) begin
                win_id          = IDW'(idx);
                win_onehot      = '0;
                win_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin front end that time-shares one booth_multiplier.
// Job completion is timed locally since the multiplier has no done flag.
module mul_share_arbiter
    import mul_share_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int W       = 5,
    parameter int RW      = 8,
    parameter int MUL_LAT = 6
) (
    input logic                clk,
    input logic                rst,
    mul_share_arbiter_if.slave bus
);
    localparam int IDW = clog2(N_REQ);
    localparam int CW  = clog2(MUL_LAT + 1);

    state_t           state;
    logic [IDW-1:0]   ptr;
    logic [CW-1:0]    cnt;
    logic [N_REQ-1:0] gnt;
    logic             mul_start;
    logic [W-1:0]     mul_m;
    logic [W-1:0]     mul_q;
    logic             rsp_valid;
    logic [IDW-1:0]   rsp_id;
    logic [RW-1:0]    rsp_result;

    logic             any;
    logic [IDW-1:0]   win_id;
    logic [N_REQ-1:0] win_onehot;
    logic [IDW-1:0]   next_ptr;
    logic [W-1:0]     win_m;
    logic [W-1:0]     win_q;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .req        (bus.req),
        .ptr        (ptr),
        .any        (any),
        .win_id     (win_id),
        .win_onehot (win_onehot)
    );

    assign next_ptr = (int'(win_id) == N_REQ - 1) ? '0
                                                  : win_id + IDW'(1);
    assign win_m = bus.req_m[int'(win_id)*W +: W];
    assign win_q = bus.req_q[int'(win_id)*W +: W];

    // The winner id doubles as rsp_id; it is only observed during RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            cnt        <= '0;
            gnt        <= '0;
            mul_start  <= 1'b0;
            mul_m      <= '0;
            mul_q      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
        end else begin
            gnt       <= '0;
            mul_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any) begin
                        rsp_id    <= win_id;
                        mul_m     <= win_m;
                        mul_q     <= win_q;
                        ptr       <= next_ptr;
                        gnt       <= win_onehot;
                        mul_start <= 1'b1;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    cnt   <= CW'(MUL_LAT - 1);
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        rsp_result <= bus.mul_result;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt        = gnt;
    assign bus.mul_start  = mul_start;
    assign bus.mul_m      = mul_m;
    assign bus.mul_q      = mul_q;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_id     = rsp_id;
    assign bus.rsp_result = rsp_result;

endmodule
